// File: rtl/ball_pkg.sv
// Shared definitions for the LED-court rally engine: direction codes,
// serve codes and the rally state enum.
package ball_pkg;

    localparam logic [1:0] DIR_IDLE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

    localparam logic [1:0] SERVE_NONE  = 2'b00;
    localparam logic [1:0] SERVE_LEFT  = 2'b01;
    localparam logic [1:0] SERVE_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MOVE_L = 2'b01,
        ST_MOVE_R = 2'b10
    } state_t;

    // Direction code shown on the display for a given rally state.
    function automatic logic [1:0] dir_of(input state_t st);
        logic [1:0] d;
        case (st)
            ST_MOVE_L: d = DIR_LEFT;
            ST_MOVE_R: d = DIR_RIGHT;
            ST_IDLE:   d = DIR_IDLE;
            default:   d = DIR_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ball_rate_gen.sv
// Ball step-rate generator. Owns the step counter and the current step
// period. restart (serve) restores the serve-speed period; speed_up (hit)
// restarts the count and, when BALL_SPEEDUP_EN is defined, shortens the
// period by SPEED_STEP down to MIN_DIV. tick is high in the last cycle of
// each period.
module ball_rate_gen #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned MIN_DIV    = 12_500_000,
    parameter int unsigned SPEED_STEP = 2_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic speed_up,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] TICK_P = CW'(TICK_DIV);

    logic [CW-1:0] count;
    logic [CW-1:0] period;
    logic [CW-1:0] period_dec;

    assign tick = (count == (period - CW'(1)));

    // Period after a successful return (clamped, never underflows).
    always_comb begin
        period_dec = period;
`ifdef BALL_SPEEDUP_EN
        if (32'(period) >= (MIN_DIV + SPEED_STEP)) begin
            period_dec = period - CW'(SPEED_STEP);
        end else begin
            period_dec = CW'(MIN_DIV);
        end
`else
        period_dec = period;
`endif
    end

    // Step counter and current period registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= CW'(0);
            period <= TICK_P;
        end else if (restart) begin
            count  <= CW'(0);
            period <= TICK_P;
        end else if (speed_up) begin
            count  <= CW'(0);
            period <= period_dec;
        end else if (tick) begin
            count  <= CW'(0);
        end else begin
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ball_court.sv
// Rally engine for the LED tennis/squash court: one-hot ball position,
// edge-detected hit buttons, saturating return counter and per-player
// point pulses. Optional feature macro: BALL_SPEEDUP_EN (ball speeds up
// on every return; handled inside ball_rate_gen).
module ball_court
    import ball_pkg::*;
#(
    parameter int unsigned N_LEDS     = 16,
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned MIN_DIV    = 12_500_000,
    parameter int unsigned SPEED_STEP = 2_500_000,
    parameter int unsigned HIT_W      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              leftdirection,
    input  logic              rightdirection,
    input  logic [1:0]        serve,
    output logic [N_LEDS-1:0] light,
    output logic [1:0]        direction,
    output logic [HIT_W-1:0]  hitnum,
    output logic              point_left,
    output logic              point_right
);

    localparam int unsigned PW = $clog2(N_LEDS);
    localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);
    localparam logic [PW-1:0] POS_FIRST = PW'(0);

    state_t            state, state_next;
    logic [PW-1:0]     position, pos_next;
    logic [HIT_W-1:0]  hit_next;
    logic              pl_next, pr_next;
    logic [N_LEDS-1:0] light_next;
    logic              left_hist, right_hist;
    logic              left_hit, right_hit;
    logic              restart, speed_up, tick;

    assign left_hit  = leftdirection  & ~left_hist;
    assign right_hit = rightdirection & ~right_hist;

    ball_rate_gen #(
        .TICK_DIV   (TICK_DIV),
        .MIN_DIV    (MIN_DIV),
        .SPEED_STEP (SPEED_STEP)
    ) u_rate (
        .clock    (clock),
        .reset    (reset),
        .restart  (restart),
        .speed_up (speed_up),
        .tick     (tick)
    );

    // Next rally state: serve, returns (hit beats tick), steps and misses.
    always_comb begin
        state_next = state;
        pos_next   = position;
        hit_next   = hitnum;
        pl_next    = 1'b0;
        pr_next    = 1'b0;
        restart    = 1'b0;
        speed_up   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (serve == SERVE_LEFT) begin
                    state_next = ST_MOVE_R;
                    pos_next   = POS_LAST;
                    hit_next   = {HIT_W{1'b0}};
                    restart    = 1'b1;
                end else if (serve == SERVE_RIGHT) begin
                    state_next = ST_MOVE_L;
                    pos_next   = POS_FIRST;
                    hit_next   = {HIT_W{1'b0}};
                    restart    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_MOVE_L: begin
                if ((position == POS_LAST) && left_hit) begin
                    state_next = ST_MOVE_R;
                    speed_up   = 1'b1;
                    hit_next   = (hitnum == {HIT_W{1'b1}}) ? hitnum : hitnum + HIT_W'(1);
                end else if (tick) begin
                    if (position == POS_LAST) begin
                        state_next = ST_IDLE;
                        pos_next   = POS_FIRST;
                        pr_next    = 1'b1;
                    end else begin
                        pos_next   = position + PW'(1);
                    end
                end else begin
                    state_next = ST_MOVE_L;
                end
            end
            ST_MOVE_R: begin
                if ((position == POS_FIRST) && right_hit) begin
                    state_next = ST_MOVE_L;
                    speed_up   = 1'b1;
                    hit_next   = (hitnum == {HIT_W{1'b1}}) ? hitnum : hitnum + HIT_W'(1);
                end else if (tick) begin
                    if (position == POS_FIRST) begin
                        state_next = ST_IDLE;
                        pl_next    = 1'b1;
                    end else begin
                        pos_next   = position - PW'(1);
                    end
                end else begin
                    state_next = ST_MOVE_R;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pos_next   = POS_FIRST;
            end
        endcase
    end

    // One-hot LED image of the next position; dark when the rally is over.
    always_comb begin
        light_next = {N_LEDS{1'b0}};
        if (state_next != ST_IDLE) begin
            light_next = {{(N_LEDS-1){1'b0}}, 1'b1} << pos_next;
        end else begin
            light_next = {N_LEDS{1'b0}};
        end
    end

    // State, position, button history and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            position    <= POS_FIRST;
            left_hist   <= 1'b0;
            right_hist  <= 1'b0;
            light       <= {N_LEDS{1'b0}};
            direction   <= DIR_IDLE;
            hitnum      <= {HIT_W{1'b0}};
            point_left  <= 1'b0;
            point_right <= 1'b0;
        end else begin
            state       <= state_next;
            position    <= pos_next;
            left_hist   <= leftdirection;
            right_hist  <= rightdirection;
            light       <= light_next;
            direction   <= dir_of(state_next);
            hitnum      <= hit_next;
            point_left  <= pl_next;
            point_right <= pr_next;
        end
    end

endmodule

// File: doc/ball_court.md
# ball_court

Parametrised rally engine for the tennis/squash LED court. It replaces the fixed 16-LED ball block with a configurable LED count, a programmable step period and an optional speed-up on each return. It also adds edge-detected hit buttons and per-player point pulses. It sits between the debounced player buttons and the LED/score display logic.

## Interface
- N_LEDS, 16: number of court LEDs, minimum 4; bit N_LEDS-1 is the left end, bit 0 is the right end.
- TICK_DIV, 50_000_000: clock cycles per ball step at serve speed, minimum 2.
- MIN_DIV, 12_500_000: fastest allowed step period, 2 ≤ MIN_DIV ≤ TICK_DIV.
- SPEED_STEP, 2_500_000: period reduction per successful return; used only with speed-up compiled in.
- HIT_W, 3: width of the hit counter.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- leftdirection  in  1  left player hit button, level-sensitive and synchronous to clock.
- rightdirection  in  1  right player hit button, level-sensitive and synchronous to clock.
- serve  in  2  serve request: 01 = left serves, 10 = right serves, 00/11 = none.
- light  out  N_LEDS  one-hot ball position; all zero when idle.
- direction  out  2  00 = idle, 01 = ball moving left (toward bit N_LEDS-1), 10 = moving right.
- hitnum  out  HIT_W  successful returns in the current rally; saturates at all-ones.
- point_left  out  1  one-cycle pulse: left player won the rally.
- point_right  out  1  one-cycle pulse: right player won the rally.

## Operation
- States: IDLE, MOVE_L, MOVE_R. Reset enters IDLE.
- Reset values: light=0, direction=00, hitnum=0, point_left=0, point_right=0, position=0, step counter=0, current period=TICK_DIV, both button history registers=0.
- IDLE, serve=01: position=N_LEDS-1, go to MOVE_R, hitnum=0, period=TICK_DIV, counter=0.
- IDLE, serve=10: position=0, go to MOVE_L, with the same clears.
- serve is ignored in MOVE_L and MOVE_R. Codes 00 and 11 are ignored in every state.
- Step counter runs 0 to period-1. A tick occurs when the counter equals period-1; the counter then wraps to 0.
- On a tick, the ball moves one position in its direction: MOVE_L increments the position, MOVE_R decrements it.
- A hit is a rising edge of a button: input sampled 1 while its history register holds 0. History registers update every cycle in every state.
- MOVE_L at position N_LEDS-1, left hit: go to MOVE_R, counter=0, hitnum+1 (saturating).
- MOVE_R at position 0, right hit: go to MOVE_L, with the same counter reset and hitnum increment.
- Hits are ignored in these cases: the ball is not at the hitter's end, the ball is moving away from the hitter, or the state is IDLE. A held button never re-triggers; it must be released and pressed again.
- Miss: a tick at the receiving end without a hit.
  - MOVE_L at N_LEDS-1: pulse point_right.
  - MOVE_R at 0: pulse point_left.
  - In both cases go to IDLE and set light=0 and direction=00. hitnum holds until the next serve.
- A hit and a tick in the same cycle: the hit wins.
- Both buttons rising in the same cycle: only the receiving player's hit is evaluated.
- A reset assertion in any state, mid-rally included, immediately forces the reset values.

## Timing
- Serve accepted at clock edge k: light and direction are valid after edge k.
- First step happens TICK_DIV cycles after the serve edge, and each later step is one period apart.
- A hit acts on the edge where the rising button is first sampled. The reversed direction is visible the next cycle.
- The first step after a hit comes one full period later.
- point_* is high for exactly one cycle, the cycle in which light becomes 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- BALL_SPEEDUP_EN defined: on every hit, period = max(MIN_DIV, period − SPEED_STEP). The result clamps to MIN_DIV and never underflows. The period is restored to TICK_DIV on serve.
- BALL_SPEEDUP_EN undefined: the period is fixed at TICK_DIV; SPEED_STEP and MIN_DIV are unused.

## Structure
- Shared package ball_pkg holds:
  - direction codes DIR_IDLE, DIR_LEFT, DIR_RIGHT;
  - serve codes SERVE_NONE, SERVE_LEFT, SERVE_RIGHT;
  - the state enum.
- Position width is $clog2(N_LEDS). Period and counter width are $clog2(TICK_DIV+1).
- One sub-module, ball_rate_gen. It owns the step counter, the current period and the speed-up logic. Inputs: restart and speed-up. Output: tick.

## Test plan
All scenarios use N_LEDS=16, TICK_DIV=4, MIN_DIV=2, SPEED_STEP=1, HIT_W=3.
- Serve 01 from IDLE, no presses:
  - light=16'h8000 and direction=10 after the serve edge;
  - 16'h4000 four cycles later;
  - 16'h0001 at cycle 60;
  - cycle 64: point_left=1 for one cycle, light=0, direction=00.
- Serve 10, right held high from before the serve, left pressed at 16'h8000:
  - the held right button never registers;
  - the left hit sets direction=10 and hitnum=1.
- Left pressed while the ball is at 16'h0100, then pressed again at 16'h8000: the first press is ignored, the second is a hit.
- With BALL_SPEEDUP_EN, alternate hits for 10 returns:
  - step spacing goes 4, 3, 2, 2, … cycles;
  - hitnum reaches 7 and holds.
- Hit arriving on the tick edge at position 0: the return is taken and no point pulse fires.
- Reset asserted mid-rally at 16'h0040: all outputs are zero asynchronously, and serve=10 still works after reset is released.
